// File: rtl/time_keeper_if.sv
`default_nettype none
// ============================================================================
// Module      : time_keeper_if
// Description : Signal bundle between the time-entry/display side (master)
//               and the time_keeper counter (slave).
//               master drives : run, load, set_* BCD digits
//               slave drives  : current-time BCD digits, sec_tick,
//                               day_wrap, load_err
// Revision    : 1.0 - initial release
// ============================================================================
interface time_keeper_if;
  logic       run;
  logic       load;
  logic [3:0] set_hrstens;
  logic [3:0] set_hrsones;
  logic [3:0] set_mintens;
  logic [3:0] set_minones;
  logic [3:0] set_sectens;
  logic [3:0] set_secones;
  logic [3:0] hrstens;
  logic [3:0] hrsones;
  logic [3:0] mintens;
  logic [3:0] minones;
  logic [3:0] sectens;
  logic [3:0] secones;
  logic       sec_tick;
  logic       day_wrap;
  logic       load_err;

  modport master (
    output run, load,
    output set_hrstens, set_hrsones, set_mintens,
    output set_minones, set_sectens, set_secones,
    input  hrstens, hrsones, mintens, minones, sectens, secones,
    input  sec_tick, day_wrap, load_err
  );

  modport slave (
    input  run, load,
    input  set_hrstens, set_hrsones, set_mintens,
    input  set_minones, set_sectens, set_secones,
    output hrstens, hrsones, mintens, minones, sectens, secones,
    output sec_tick, day_wrap, load_err
  );
endinterface
`default_nettype wire

// File: rtl/time_keeper.sv
`default_nettype none
// ============================================================================
// Module      : time_keeper
// Description : Time-of-day counter (HH:MM:SS, six BCD digits). Captures the
//               entry-stage digits on a validated load strobe and advances
//               once per second while run is high. The 1 Hz tick comes from
//               an internal prescaler of TICK_DIV system-clock cycles.
// Ports       : clk    - system clock, rising edge
//               rst_n  - asynchronous active-low reset
//               tk     - time_keeper_if.slave: run/load/set_* in,
//                        time digits and sec_tick/day_wrap/load_err out
// Revision    : 1.0 - initial release
// ============================================================================
module time_keeper #(
  parameter int TICK_DIV = 100000000
) (
  input  wire logic    clk,
  input  wire logic    rst_n,
  time_keeper_if.slave tk
);

  localparam int                 c_DIV_W   = $clog2(TICK_DIV);
  localparam logic [c_DIV_W-1:0] c_DIV_MAX = c_DIV_W'(TICK_DIV - 1);

  logic [c_DIV_W-1:0] r_div;
  logic [3:0]         r_hrstens, r_hrsones, r_mintens, r_minones, r_sectens, r_secones;
  logic               r_sec_tick, r_day_wrap, r_load_err;

  logic               w_valid, w_load_ok, w_load_bad, w_tick, w_at_max;
  logic [c_DIV_W-1:0] w_div_nxt;
  logic [3:0]         w_hrstens, w_hrsones, w_mintens, w_minones, w_sectens, w_secones;
  logic               w_c0, w_c1, w_c2, w_c3;

  // Hours <= 23 is checked digit-wise so no multiply is needed.
  assign w_valid = (tk.set_hrstens <= 4'd2) && (tk.set_hrsones <= 4'd9) &&
                   ((tk.set_hrstens < 4'd2) || (tk.set_hrsones <= 4'd3)) &&
                   (tk.set_mintens <= 4'd5) && (tk.set_minones <= 4'd9) &&
                   (tk.set_sectens <= 4'd5) && (tk.set_secones <= 4'd9);

  assign w_load_ok  = tk.load &  w_valid;
  assign w_load_bad = tk.load & ~w_valid;

  // A rejected load is transparent to counting; only an accepted one
  // suppresses the tick and restarts the prescaler.
  assign w_tick   = tk.run && (r_div == c_DIV_MAX) && !w_load_ok;

  assign w_at_max = (r_hrstens == 4'd2) && (r_hrsones == 4'd3) &&
                    (r_mintens == 4'd5) && (r_minones == 4'd9) &&
                    (r_sectens == 4'd5) && (r_secones == 4'd9);

  always_comb begin
    w_div_nxt = r_div;
    if (!tk.run || w_load_ok || (r_div == c_DIV_MAX)) begin
      w_div_nxt = '0;
    end else begin
      w_div_nxt = r_div + c_DIV_W'(1);
    end
  end

  // One-second BCD ripple increment of the current time.
  always_comb begin
    w_c0      = (r_secones == 4'd9);
    w_c1      = w_c0 && (r_sectens == 4'd5);
    w_c2      = w_c1 && (r_minones == 4'd9);
    w_c3      = w_c2 && (r_mintens == 4'd5);

    w_secones = w_c0 ? 4'd0 : r_secones + 4'd1;
    w_sectens = r_sectens;
    w_minones = r_minones;
    w_mintens = r_mintens;
    w_hrsones = r_hrsones;
    w_hrstens = r_hrstens;

    if (w_c0) w_sectens = (r_sectens == 4'd5) ? 4'd0 : r_sectens + 4'd1;
    if (w_c1) w_minones = (r_minones == 4'd9) ? 4'd0 : r_minones + 4'd1;
    if (w_c2) w_mintens = (r_mintens == 4'd5) ? 4'd0 : r_mintens + 4'd1;
    if (w_c3) begin
      if ((r_hrstens == 4'd2) && (r_hrsones == 4'd3)) begin
        w_hrstens = 4'd0;
        w_hrsones = 4'd0;
      end else if (r_hrsones == 4'd9) begin
        w_hrsones = 4'd0;
        w_hrstens = r_hrstens + 4'd1;
      end else begin
        w_hrsones = r_hrsones + 4'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_div      <= '0;
      r_hrstens  <= 4'd0;
      r_hrsones  <= 4'd0;
      r_mintens  <= 4'd0;
      r_minones  <= 4'd0;
      r_sectens  <= 4'd0;
      r_secones  <= 4'd0;
      r_sec_tick <= 1'b0;
      r_day_wrap <= 1'b0;
      r_load_err <= 1'b0;
    end else begin
      r_div      <= w_div_nxt;
      r_sec_tick <= w_tick;
      r_day_wrap <= w_tick && w_at_max;
      r_load_err <= w_load_bad;
      if (w_load_ok) begin
        r_hrstens <= tk.set_hrstens;
        r_hrsones <= tk.set_hrsones;
        r_mintens <= tk.set_mintens;
        r_minones <= tk.set_minones;
        r_sectens <= tk.set_sectens;
        r_secones <= tk.set_secones;
      end else if (w_tick) begin
        r_hrstens <= w_hrstens;
        r_hrsones <= w_hrsones;
        r_mintens <= w_mintens;
        r_minones <= w_minones;
        r_sectens <= w_sectens;
        r_secones <= w_secones;
      end
    end
  end

  assign tk.hrstens  = r_hrstens;
  assign tk.hrsones  = r_hrsones;
  assign tk.mintens  = r_mintens;
  assign tk.minones  = r_minones;
  assign tk.sectens  = r_sectens;
  assign tk.secones  = r_secones;
  assign tk.sec_tick = r_sec_tick;
  assign tk.day_wrap = r_day_wrap;
  assign tk.load_err = r_load_err;

endmodule
`default_nettype wire

// File: tb/tb_time_keeper.sv
`default_nettype none
// ============================================================================
// Module      : tb_time_keeper
// Description : Self-checking bench for time_keeper (TICK_DIV = 4). Directed
//               stimulus pushes expected pulse events (cycle, time, flags)
//               into a queue; a monitor pops and compares on every cycle in
//               which the DUT raises sec_tick, day_wrap or load_err.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_time_keeper;

  localparam int c_TICK_DIV = 4;

  typedef struct {
    int unsigned at;
    logic [23:0] t;
    logic        st;
    logic        dw;
    logic        le;
  } exp_t;

  logic        clk;
  logic        rst_n;
  int unsigned cyc;
  int          n_tests;
  int          n_fail;
  exp_t        q[$];
  exp_t        m_e;

  time_keeper_if tk ();

  time_keeper #(.TICK_DIV(c_TICK_DIV)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .tk    (tk)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [23:0] now_t();
    return {tk.hrstens, tk.hrsones, tk.mintens, tk.minones, tk.sectens, tk.secones};
  endfunction

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Queue an expected pulse event `dly` edges after the current one.
  task automatic expect_ev(input int unsigned dly, input logic [23:0] t,
                           input logic st, input logic dw, input logic le);
    exp_t e;
    e.at = cyc + dly;
    e.t  = t;
    e.st = st;
    e.dw = dw;
    e.le = le;
    q.push_back(e);
  endtask

  task automatic do_load(input logic [23:0] t);
    {tk.set_hrstens, tk.set_hrsones, tk.set_mintens,
     tk.set_minones, tk.set_sectens, tk.set_secones} = t;
    tk.load = 1'b1;
    @(posedge clk);
    #1;
    tk.load = 1'b0;
  endtask

  task automatic chk_time(input string name, input logic [23:0] exp_v);
    n_tests++;
    if (now_t() !== exp_v) begin
      n_fail++;
      $display("FAIL %s: time got %h expected %h", name, now_t(), exp_v);
    end
  endtask

  task automatic chk_quiet(input string name);
    n_tests++;
    if ({tk.sec_tick, tk.day_wrap, tk.load_err} !== 3'b000) begin
      n_fail++;
      $display("FAIL %s: st/dw/le got %b%b%b expected 000", name,
               tk.sec_tick, tk.day_wrap, tk.load_err);
    end
  endtask

  // Scoreboard monitor: every pulse cycle must match the next queued event.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && (tk.sec_tick || tk.day_wrap || tk.load_err)) begin
      n_tests++;
      if (q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_pulse: cyc %0d st/dw/le %b%b%b time %h expected no pulse",
                 cyc, tk.sec_tick, tk.day_wrap, tk.load_err, now_t());
      end else begin
        m_e = q.pop_front();
        if (cyc != m_e.at || now_t() !== m_e.t || tk.sec_tick !== m_e.st ||
            tk.day_wrap !== m_e.dw || tk.load_err !== m_e.le) begin
          n_fail++;
          $display("FAIL event: got cyc %0d time %h st/dw/le %b%b%b expected cyc %0d time %h st/dw/le %b%b%b",
                   cyc, now_t(), tk.sec_tick, tk.day_wrap, tk.load_err,
                   m_e.at, m_e.t, m_e.st, m_e.dw, m_e.le);
        end
      end
    end
  end

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst_n   = 1'b0;
    tk.run  = 1'b0;
    tk.load = 1'b0;
    {tk.set_hrstens, tk.set_hrsones, tk.set_mintens,
     tk.set_minones, tk.set_sectens, tk.set_secones} = 24'h0;

    step(2);
    chk_time("reset_time", 24'h000000);
    chk_quiet("reset_pulses");

    // Free run from reset: ticks on the 4th, 8th and 12th edge.
    rst_n  = 1'b1;
    tk.run = 1'b1;
    expect_ev(4,  24'h000001, 1'b1, 1'b0, 1'b0);
    expect_ev(8,  24'h000002, 1'b1, 1'b0, 1'b0);
    expect_ev(12, 24'h000003, 1'b1, 1'b0, 1'b0);
    step(12);
    chk_time("run_12_edges", 24'h000003);

    // Day wrap.
    expect_ev(5, 24'h235959, 1'b1, 1'b0, 1'b0);
    expect_ev(9, 24'h000000, 1'b1, 1'b1, 1'b0);
    do_load(24'h235958);
    chk_time("load_235958", 24'h235958);
    step(8);
    chk_time("day_wrap_time", 24'h000000);

    // Minute carry, then hrsones carry into hrstens.
    expect_ev(5, 24'h121000, 1'b1, 1'b0, 1'b0);
    do_load(24'h120959);
    step(4);
    chk_time("min_carry", 24'h121000);
    expect_ev(5, 24'h100000, 1'b1, 1'b0, 1'b0);
    do_load(24'h095959);
    step(4);
    chk_time("hr_carry", 24'h100000);

    // Rejected loads: load_err each, time kept, prescaler keeps counting.
    expect_ev(1, 24'h100000, 1'b0, 1'b0, 1'b1);
    expect_ev(2, 24'h100000, 1'b0, 1'b0, 1'b1);
    expect_ev(3, 24'h100000, 1'b0, 1'b0, 1'b1);
    expect_ev(4, 24'h100001, 1'b1, 1'b0, 1'b0);
    do_load(24'h240000);
    chk_time("bad_hours", 24'h100000);
    do_load(24'h126000);
    chk_time("bad_mintens", 24'h100000);
    do_load(24'h00000A);
    chk_time("bad_secones", 24'h100000);
    step(1);
    chk_time("bad_load_count", 24'h100001);

    // Valid load collides with a tick: load wins, tick lost.
    step(3);
    expect_ev(5, 24'h053001, 1'b1, 1'b0, 1'b0);
    do_load(24'h053000);
    chk_time("load_beats_tick", 24'h053000);
    chk_quiet("load_beats_tick_pulse");
    step(4);
    chk_time("tick_after_load", 24'h053001);

    // Freeze mid-count, then reassert for a full period.
    step(2);
    tk.run = 1'b0;
    step(10);
    chk_time("frozen", 24'h053001);
    tk.run = 1'b1;
    expect_ev(4, 24'h053002, 1'b1, 1'b0, 1'b0);
    step(4);
    chk_time("rerun_full_period", 24'h053002);

    // Asynchronous reset between edges.
    step(2);
    #1 rst_n = 1'b0;
    #1;
    chk_time("async_reset", 24'h000000);
    chk_quiet("async_reset_pulses");
    #1 rst_n = 1'b1;
    expect_ev(4, 24'h000001, 1'b1, 1'b0, 1'b0);
    step(4);
    chk_time("after_reset_release", 24'h000001);

    step(1);
    n_tests++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL missing_events: %0d pending expected 0", q.size());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
